// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  // Modulo-n increment, valid for non-power-of-2 n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Finds the first set request bit at or after start, wrapping past N_REQ-1 to 0.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan offsets from the far end so the nearest hit to start wins.
  always_comb begin
    found   = 1'b0;
    idx     = start;
    pos     = 0;
    pos_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      pos     = (32'(start) + 32'(off)) % N_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter sharing one synfifo write port among N_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_cs,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        grant_valid,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_idx
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             cur_valid;
  logic             xfer;
  logic             in_grant;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_idx <= grant_idx_d;
      beat_cnt  <= beat_cnt_d;
    end
  end

  assign in_grant  = (state == GRANT);
  assign cur_valid = req_valid[grant_idx];
  assign xfer      = in_grant & cur_valid & ~fifo_full;

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    grant_idx_d = grant_idx;
    beat_cnt_d  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!cur_valid) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(rr_next(32'(grant_idx), N_REQ));
        end else if (xfer) begin
          beat_cnt_d = beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = IDX_W'(rr_next(32'(grant_idx), N_REQ));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO-side drive and one-hot ready decode on the registered grantee.
  always_comb begin
    req_ready = '0;
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_grant && grant_idx == IDX_W'(i)) begin
        req_ready[i] = ~fifo_full;
        fifo_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_valid = in_grant;
  assign fifo_cs     = in_grant;
  assign fifo_wr_en  = xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus multi-cycle corner sequences.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_cs;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  logic [DW-1:0]   dat [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
  end

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_cs     (fifo_cs),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  typedef struct {
    logic [3:0]  valid;
    logic        full;
    logic [3:0]  ready;
    logic        wr;
    logic [31:0] data;
    logic        gv;
    logic [1:0]  gidx;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_wr [9];
    logic exp_gv [9];
    int   sent;

    for (int i = 0; i < N; i++) dat[i] = 32'hD0 + 32'(i);

    //        valid    full  ready    wr    data       gv    gidx
    tbl[0]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 32'hD0, 1'b1, 2'd0};
    tbl[2]  = '{4'b1110, 1'b0, 4'b0001, 1'b0, 32'hD0, 1'b1, 2'd0};
    tbl[3]  = '{4'b1110, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[4]  = '{4'b1110, 1'b0, 4'b0010, 1'b1, 32'hD1, 1'b1, 2'd1};
    tbl[5]  = '{4'b1100, 1'b0, 4'b0010, 1'b0, 32'hD1, 1'b1, 2'd1};
    tbl[6]  = '{4'b1100, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd1};
    tbl[7]  = '{4'b1100, 1'b0, 4'b0100, 1'b1, 32'hD2, 1'b1, 2'd2};
    tbl[8]  = '{4'b1000, 1'b0, 4'b0100, 1'b0, 32'hD2, 1'b1, 2'd2};
    tbl[9]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd2};
    tbl[10] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 32'hD3, 1'b1, 2'd3};
    tbl[11] = '{4'b0001, 1'b0, 4'b1000, 1'b0, 32'hD3, 1'b1, 2'd3};
    tbl[12] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd3};
    tbl[13] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 32'hD0, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 32'hD0, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[17] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[18] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 32'hD2, 1'b1, 2'd2};
    tbl[19] = '{4'b0001, 1'b0, 4'b0100, 1'b0, 32'hD2, 1'b1, 2'd2};
    tbl[20] = '{4'b0101, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd2};
    tbl[21] = '{4'b0101, 1'b0, 4'b0001, 1'b1, 32'hD0, 1'b1, 2'd0};
    tbl[22] = '{4'b0100, 1'b0, 4'b0001, 1'b0, 32'hD0, 1'b1, 2'd0};
    tbl[23] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd0};
    tbl[24] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 32'hD2, 1'b1, 2'd2};
    tbl[25] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 32'hD2, 1'b1, 2'd2};
    tbl[26] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h00, 1'b0, 2'd2};

    // Round robin, wrap priority, idle/full no-write: one row per clock.
    do_reset();
    chk("reset rr_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("reset beat_cnt", 64'(dut.beat_cnt), 64'd0);
    for (int r = 0; r < 27; r++) begin
      req_valid = tbl[r].valid;
      fifo_full = tbl[r].full;
      @(negedge clk);
      chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(tbl[r].ready));
      chk($sformatf("row%0d fifo_wr_en", r), 64'(fifo_wr_en), 64'(tbl[r].wr));
      chk($sformatf("row%0d fifo_data", r), 64'(fifo_data), 64'(tbl[r].data));
      chk($sformatf("row%0d grant_valid", r), 64'(grant_valid), 64'(tbl[r].gv));
      chk($sformatf("row%0d fifo_cs", r), 64'(fifo_cs), 64'(tbl[r].gv));
      chk($sformatf("row%0d grant_idx", r), 64'(grant_idx), 64'(tbl[r].gidx));
      tick();
    end

    // Single requester: four capped beats, one IDLE, regrant for the rest.
    do_reset();
    exp_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_gv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    sent = 0;
    for (int c = 0; c < 9; c++) begin
      req_valid = (sent < 6) ? 4'b0001 : 4'b0000;
      dat[0]    = 32'hA0 + 32'(sent);
      @(negedge clk);
      chk($sformatf("single c%0d wr_en", c), 64'(fifo_wr_en), 64'(exp_wr[c]));
      chk($sformatf("single c%0d grant_valid", c), 64'(grant_valid), 64'(exp_gv[c]));
      if (exp_wr[c])
        chk($sformatf("single c%0d data", c), 64'(fifo_data),
            64'((c < 5) ? (32'hA0 + 32'(c - 1)) : (32'hA4 + 32'(c - 6))));
      if (req_ready[0] && req_valid[0]) sent++;
      tick();
    end
    chk("single beats written", 64'(sent), 64'd6);

    // Backpressure mid-burst: hold for three full cycles, then finish to the cap.
    do_reset();
    exp_wr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sent = 0;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 8) ? 4'b0010 : 4'b0000;
      fifo_full = (c >= 3 && c <= 5);
      dat[1]    = 32'hB0 + 32'(sent);
      @(negedge clk);
      chk($sformatf("bp c%0d wr_en", c), 64'(fifo_wr_en), 64'(exp_wr[c]));
      if (exp_wr[c])
        chk($sformatf("bp c%0d data", c), 64'(fifo_data), 64'(32'hB0 + 32'(sent)));
      if (c >= 3 && c <= 5) begin
        chk($sformatf("bp c%0d ready", c), 64'(req_ready), 64'd0);
        chk($sformatf("bp c%0d grant_idx", c), 64'(grant_idx), 64'd1);
        chk($sformatf("bp c%0d grant_valid", c), 64'(grant_valid), 64'd1);
        chk($sformatf("bp c%0d beat_cnt", c), 64'(dut.beat_cnt), 64'd2);
      end
      if (req_ready[1] && req_valid[1]) sent++;
      tick();
    end
    chk("bp release grant_valid", 64'(grant_valid), 64'd0);
    chk("bp release rr_ptr", 64'(dut.rr_ptr), 64'd2);
    chk("bp beats written", 64'(sent), 64'd4);

    // Valid drop after two beats hands over to the next requester.
    do_reset();
    fifo_full = 1'b0;
    dat[0]    = 32'hC0;
    dat[1]    = 32'hC1;
    req_valid = 4'b0011;
    tick();
    @(negedge clk);
    chk("drop beat1 wr_en", 64'(fifo_wr_en), 64'd1);
    tick();
    @(negedge clk);
    chk("drop beat2 wr_en", 64'(fifo_wr_en), 64'd1);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("drop no-beat wr_en", 64'(fifo_wr_en), 64'd0);
    chk("drop beat_cnt", 64'(dut.beat_cnt), 64'd2);
    tick();
    chk("drop idle grant_valid", 64'(grant_valid), 64'd0);
    chk("drop rr_ptr", 64'(dut.rr_ptr), 64'd1);
    chk("drop beat_cnt held", 64'(dut.beat_cnt), 64'd2);
    tick();
    @(negedge clk);
    chk("drop next grant_idx", 64'(grant_idx), 64'd1);
    chk("drop next data", 64'(fifo_data), 64'hC1);
    chk("drop next wr_en", 64'(fifo_wr_en), 64'd1);

    // Asynchronous reset during GRANT clears outputs at once; arbitration restarts at 0.
    do_reset();
    dat[0]    = 32'hE0;
    dat[2]    = 32'hE2;
    req_valid = 4'b0100;
    tick();
    @(negedge clk);
    chk("rst pre grant_idx", 64'(grant_idx), 64'd2);
    chk("rst pre wr_en", 64'(fifo_wr_en), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst async ready", 64'(req_ready), 64'd0);
    chk("rst async wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst async cs", 64'(fifo_cs), 64'd0);
    chk("rst async grant_valid", 64'(grant_valid), 64'd0);
    chk("rst async grant_idx", 64'(grant_idx), 64'd0);
    chk("rst async data", 64'(fifo_data), 64'd0);
    req_valid = 4'b0101;
    @(negedge clk);
    chk("rst held wr_en", 64'(fifo_wr_en), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst after grant_valid", 64'(grant_valid), 64'd1);
    chk("rst after grant_idx", 64'(grant_idx), 64'd0);
    chk("rst after data", 64'(fifo_data), 64'hE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
